// File: rtl/ui_msg_composer.sv
// ui_msg_composer: composes a fixed-template UI status message, optionally
// followed by phone digits. It emits the message as a contiguous ASCII burst
// and then holds a GAP_CYCLES idle gap before done.
// Optional one-entry request queue: define UI_MSG_QUEUE_EN.
module ui_msg_composer #(
   parameter int GAP_CYCLES = 2,
   parameter int MAX_DIGITS = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [2:0]              msg_sel,
   input  logic [4*MAX_DIGITS-1:0] phone_num,
   input  logic [3:0]              num_digits,
   output logic [7:0]              ascii_data,
   output logic                    ascii_data_ready,
   output logic                    busy,
   output logic                    done
);

   localparam int PW = 4 * MAX_DIGITS;

   typedef enum logic [1:0] {IDLE, PREFIX, DIGITS, GAP} state_t;

   state_t          state_q;
   logic [7:0]      data_q;
   logic            ready_q;
   logic            busy_q;
   logic            done_q;
   logic [2:0]      msg_q;
   logic [PW-1:0]   phone_q;
   logic [3:0]      nd_q;
   logic [3:0]      idx_q;
   logic [3:0]      gap_q;

   // launch request presented to the FSM while in IDLE
   logic            launch_d;
   logic [2:0]      msg_d;
   logic [PW-1:0]   phone_d;
   logic [3:0]      nd_d;

   // template ROM, each entry right-padded to 10 characters
   function automatic logic [79:0] tmpl_text(input logic [2:0] m);
      case (m)
         3'd0:    tmpl_text = "CALLING   ";
         3'd1:    tmpl_text = "INCOMING  ";
         3'd2:    tmpl_text = "CONNECTED ";
         3'd3:    tmpl_text = "MISSED    ";
         3'd4:    tmpl_text = "CALL ENDED";
         3'd5:    tmpl_text = "LINE BUSY ";
         3'd6:    tmpl_text = "NO ANSWER ";
         default: tmpl_text = "READY     ";
      endcase
   endfunction

   function automatic logic [3:0] tmpl_len(input logic [2:0] m);
      case (m)
         3'd0:    tmpl_len = 4'd8;
         3'd1:    tmpl_len = 4'd9;
         3'd2:    tmpl_len = 4'd10;
         3'd3:    tmpl_len = 4'd7;
         3'd4:    tmpl_len = 4'd10;
         3'd5:    tmpl_len = 4'd9;
         3'd6:    tmpl_len = 4'd9;
         default: tmpl_len = 4'd5;
      endcase
   endfunction

   // templates 0-3 append the phone number
   function automatic logic tmpl_app(input logic [2:0] m);
      return ~m[2];
   endfunction

   function automatic logic [7:0] tmpl_char(input logic [2:0] m, input logic [3:0] i);
      logic [79:0] t;
      t = tmpl_text(m);
      return t[8*(9-int'(i)) +: 8];
   endfunction

   function automatic logic [7:0] digit_ascii(input logic [3:0] d);
      if (d <= 4'd9)       return {4'h3, d};
      else if (d == 4'hA)  return 8'h2A;
      else if (d == 4'hB)  return 8'h23;
      else                 return 8'h3F;
   endfunction

   function automatic logic [3:0] clamp_nd(input logic [3:0] n);
      return (int'(n) > MAX_DIGITS) ? 4'(MAX_DIGITS) : n;
   endfunction

`ifdef UI_MSG_QUEUE_EN
   logic            q_valid_q;
   logic [2:0]      q_msg_q;
   logic [PW-1:0]   q_phone_q;
   logic [3:0]      q_nd_q;

   // a queued request takes priority over a fresh start in IDLE
   always_comb begin
      if (q_valid_q) begin
         launch_d = 1'b1;
         msg_d    = q_msg_q;
         phone_d  = q_phone_q;
         nd_d     = q_nd_q;
      end else begin
         launch_d = start;
         msg_d    = msg_sel;
         phone_d  = phone_num;
         nd_d     = clamp_nd(num_digits);
      end
   end

   // one-entry queue: fill on start while busy, drain when IDLE launches it
   always_ff @(posedge clk) begin
      if (reset) begin
         q_valid_q <= 1'b0;
         q_msg_q   <= '0;
         q_phone_q <= '0;
         q_nd_q    <= '0;
      end else if (state_q != IDLE) begin
         if (start && !q_valid_q) begin
            q_valid_q <= 1'b1;
            q_msg_q   <= msg_sel;
            q_phone_q <= phone_num;
            q_nd_q    <= clamp_nd(num_digits);
         end
      end else if (q_valid_q) begin
         // entry launches this edge; a simultaneous start refills the slot
         q_valid_q <= start;
         if (start) begin
            q_msg_q   <= msg_sel;
            q_phone_q <= phone_num;
            q_nd_q    <= clamp_nd(num_digits);
         end
      end
   end
`else
   // no queue: only a start seen in IDLE launches a message
   always_comb begin
      launch_d = start;
      msg_d    = msg_sel;
      phone_d  = phone_num;
      nd_d     = clamp_nd(num_digits);
   end
`endif

   // message FSM with registered outputs; data_q always holds the character on the bus
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         msg_q   <= '0;
         phone_q <= '0;
         nd_q    <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch_d) begin
                  state_q <= PREFIX;
                  msg_q   <= msg_d;
                  phone_q <= phone_d;
                  nd_q    <= nd_d;
                  idx_q   <= '0;
                  data_q  <= tmpl_char(msg_d, 4'd0);
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            PREFIX: begin
               if (idx_q != tmpl_len(msg_q) - 4'd1) begin
                  idx_q  <= idx_q + 4'd1;
                  data_q <= tmpl_char(msg_q, idx_q + 4'd1);
               end else if (tmpl_app(msg_q) && nd_q != '0) begin
                  state_q <= DIGITS;
                  idx_q   <= '0;
                  data_q  <= digit_ascii(phone_q[PW-1 -: 4]);
                  phone_q <= phone_q << 4;
               end else begin
                  state_q <= GAP;
                  ready_q <= 1'b0;
                  data_q  <= '0;
                  gap_q   <= '0;
               end
            end
            DIGITS: begin
               if (idx_q != nd_q - 4'd1) begin
                  idx_q   <= idx_q + 4'd1;
                  data_q  <= digit_ascii(phone_q[PW-1 -: 4]);
                  phone_q <= phone_q << 4;
               end else begin
                  state_q <= GAP;
                  ready_q <= 1'b0;
                  data_q  <= '0;
                  gap_q   <= '0;
               end
            end
            GAP: begin
               if (gap_q == 4'(GAP_CYCLES - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  gap_q <= gap_q + 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ascii_data       = data_q;
   assign ascii_data_ready = ready_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: tb/tb_ui_msg_composer.sv
// Testbench for ui_msg_composer: expected characters are queued when a
// request is driven and popped by a monitor as the DUT emits them.
module tb_ui_msg_composer;

   localparam int GAP = 2;
   localparam int MAXD = 10;

   logic            clk;
   logic            reset;
   logic            start;
   logic [2:0]      msg_sel;
   logic [39:0]     phone_num;
   logic [3:0]      num_digits;
   logic [7:0]      ascii_data;
   logic            ascii_data_ready;
   logic            busy;
   logic            done;

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;
   logic [7:0] exp_q[$];

   string TMPL [8] = '{"CALLING ", "INCOMING ", "CONNECTED ", "MISSED ",
                       "CALL ENDED", "LINE BUSY", "NO ANSWER", "READY"};
   bit    APP  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

   ui_msg_composer #(.GAP_CYCLES(GAP), .MAX_DIGITS(MAXD)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .msg_sel          (msg_sel),
      .phone_num        (phone_num),
      .num_digits       (num_digits),
      .ascii_data       (ascii_data),
      .ascii_data_ready (ascii_data_ready),
      .busy             (busy),
      .done             (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard monitor: every ready cycle pops one expected character
   always @(negedge clk) begin
      if (mon_en) begin
         if (ascii_data_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL char_unexpected: got %h, no character expected", ascii_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (ascii_data !== e) begin
                  errors++;
                  $display("FAIL char: got %h, expected %h", ascii_data, e);
               end
            end
         end else begin
            checks++;
            if (ascii_data !== 8'h00) begin
               errors++;
               $display("FAIL idle_data: got %h, expected 00 (ready=%b)", ascii_data, ascii_data_ready);
            end
         end
      end
   end

   function automatic logic [7:0] dmap(input logic [3:0] d);
      if (d <= 4'd9) return 8'h30 + {4'h0, d};
      if (d == 4'hA) return 8'h2A;
      if (d == 4'hB) return 8'h23;
      return 8'h3F;
   endfunction

   function automatic void push_expected(input int m, input logic [39:0] ph, input int nd);
      string s;
      int n;
      logic [3:0] d;
      s = TMPL[m];
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      if (APP[m]) begin
         n = (nd > MAXD) ? MAXD : nd;
         for (int i = 0; i < n; i++) begin
            d = ph[39-4*i -: 4];
            exp_q.push_back(dmap(d));
         end
      end
   endfunction

   // drive a one-cycle start from a negedge; returns on the following negedge
   task automatic pulse_start(input int m, input logic [39:0] ph, input int nd);
      msg_sel    = 3'(m);
      phone_num  = ph;
      num_digits = 4'(nd);
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic send_start(input int m, input logic [39:0] ph, input int nd);
      push_expected(m, ph, nd);
      pulse_start(m, ph, nd);
   endtask

   // measures the rest of a burst and its gap; returns on the negedge where done is seen
   task automatic measure(output int len, output int gap, output int bcnt,
                          output bit rerise, output bit to);
      int n;
      len = 0; gap = 0; bcnt = 0; rerise = 0; to = 0; n = 0;
      while (ascii_data_ready === 1'b1 && n < 100) begin
         len++;
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         n++;
      end
      while (done !== 1'b1 && n < 100) begin
         gap++;
         if (busy === 1'b1) bcnt++;
         if (ascii_data_ready === 1'b1) rerise = 1;
         @(negedge clk);
         n++;
      end
      if (n >= 100) to = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; msg_sel = '0; phone_num = '0; num_digits = '0;
      repeat (3) @(negedge clk);
      checks += 4;
      if (ascii_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", ascii_data); end
      if (ascii_data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", ascii_data_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
      mon_en = 1;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ready();
      int len, gap, bcnt; bit rr, to;
      checks++;
      if (ascii_data_ready !== 1'b0) begin errors++; $display("FAIL ready_pre: got %b, expected 0", ascii_data_ready); end
      send_start(7, '0, 0);
      checks += 2;
      if (ascii_data_ready !== 1'b1) begin errors++; $display("FAIL ready_latency: got %b, expected 1", ascii_data_ready); end
      if (busy !== 1'b1) begin errors++; $display("FAIL ready_busy_rise: got %b, expected 1", busy); end
      measure(len, gap, bcnt, rr, to);
      checks += 8;
      if (to) begin errors++; $display("FAIL ready_timeout: got timeout, expected done"); end
      if (len != 5) begin errors++; $display("FAIL ready_len: got %0d, expected 5", len); end
      if (gap != GAP) begin errors++; $display("FAIL ready_gap: got %0d, expected %0d", gap, GAP); end
      if (bcnt != 5 + GAP) begin errors++; $display("FAIL ready_busy_cycles: got %0d, expected %0d", bcnt, 5 + GAP); end
      if (rr) begin errors++; $display("FAIL ready_rerise: got 1, expected 0"); end
      if (busy !== 1'b0) begin errors++; $display("FAIL ready_busy_at_done: got %b, expected 0", busy); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL ready_left: got %0d, expected 0", exp_q.size()); end
      @(negedge clk);
      if (done !== 1'b0) begin errors++; $display("FAIL ready_done_pulse: got %b, expected 0", done); end
   endtask

   task automatic test_digits();
      int len, gap, bcnt; bit rr, to;
      send_start(0, 40'h6175551234, 10);
      phone_num = 40'h9999999999;
      measure(len, gap, bcnt, rr, to);
      checks += 4;
      if (to || len != 18) begin errors++; $display("FAIL digits_len: got %0d (to=%b), expected 18", len, to); end
      if (gap != GAP) begin errors++; $display("FAIL digits_gap: got %0d, expected %0d", gap, GAP); end
      if (rr) begin errors++; $display("FAIL digits_rerise: got 1, expected 0"); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL digits_left: got %0d, expected 0", exp_q.size()); end
      @(negedge clk);
   endtask

   task automatic test_clamp();
      int len, gap, bcnt; bit rr, to;
      send_start(1, 40'hAB0123CDEF, 15);
      measure(len, gap, bcnt, rr, to);
      checks += 2;
      if (to || len != 19) begin errors++; $display("FAIL clamp_len: got %0d (to=%b), expected 19", len, to); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL clamp_left: got %0d, expected 0", exp_q.size()); end
      @(negedge clk);
   endtask

   task automatic test_no_append();
      int len, gap, bcnt; bit rr, to;
      send_start(3, 40'h1234567890, 0);
      measure(len, gap, bcnt, rr, to);
      checks += 2;
      if (to || len != 7) begin errors++; $display("FAIL missed_len: got %0d (to=%b), expected 7", len, to); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL missed_left: got %0d, expected 0", exp_q.size()); end
      @(negedge clk);
      send_start(4, 40'h1234567890, 5);
      measure(len, gap, bcnt, rr, to);
      checks += 2;
      if (to || len != 10) begin errors++; $display("FAIL ended_len: got %0d (to=%b), expected 10", len, to); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL ended_left: got %0d, expected 0", exp_q.size()); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int len, gap, bcnt; bit rr, to;
      send_start(5, '0, 0);
      measure(len, gap, bcnt, rr, to);
      checks++;
      if (to || len != 9) begin errors++; $display("FAIL b2b_first_len: got %0d (to=%b), expected 9", len, to); end
      // start issued in the done cycle
      send_start(6, '0, 3);
      checks++;
      if (ascii_data_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b, expected 1", ascii_data_ready); end
      measure(len, gap, bcnt, rr, to);
      checks += 3;
      if (to || len != 9) begin errors++; $display("FAIL b2b_second_len: got %0d (to=%b), expected 9", len, to); end
      if (gap != GAP) begin errors++; $display("FAIL b2b_gap: got %0d, expected %0d", gap, GAP); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d, expected 0", exp_q.size()); end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      int len, gap, bcnt, seen; bit rr, to;
      send_start(2, 40'h5550000000, 3);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks += 4;
      if (ascii_data_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %b, expected 0", ascii_data_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b, expected 0", busy); end
      if (ascii_data !== 8'h00) begin errors++; $display("FAIL mrst_data: got %h, expected 00", ascii_data); end
      if (done !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b, expected 0", done); end
      reset = 1'b0;
      seen = 0;
      repeat (GAP + 4) begin
         @(negedge clk);
         if (done === 1'b1 || ascii_data_ready === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL mrst_quiet: got %0d active cycles, expected 0", seen); end
      exp_q.delete();
      send_start(7, '0, 0);
      measure(len, gap, bcnt, rr, to);
      checks += 2;
      if (to || len != 5) begin errors++; $display("FAIL mrst_restart_len: got %0d (to=%b), expected 5", len, to); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL mrst_left: got %0d, expected 0", exp_q.size()); end
      @(negedge clk);
   endtask

   task automatic test_busy_start();
      int len, gap, bcnt, seen; bit rr, to;
      send_start(7, '0, 0);
      @(negedge clk);
      pulse_start(6, '0, 0);
`ifdef UI_MSG_QUEUE_EN
      push_expected(6, '0, 0);
`endif
      pulse_start(5, '0, 0);
      measure(len, gap, bcnt, rr, to);
      checks++;
      if (to || len != 2) begin errors++; $display("FAIL busy_first_len: got %0d (to=%b), expected 2", len, to); end
`ifdef UI_MSG_QUEUE_EN
      checks++;
      if (ascii_data_ready !== 1'b0) begin errors++; $display("FAIL queue_idle_cycle: got %b, expected 0", ascii_data_ready); end
      @(negedge clk);
      measure(len, gap, bcnt, rr, to);
      checks++;
      if (to || len != 9) begin errors++; $display("FAIL queue_len: got %0d (to=%b), expected 9", len, to); end
`endif
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (ascii_data_ready === 1'b1 || busy === 1'b1) seen++;
      end
      checks += 2;
      if (seen != 0) begin errors++; $display("FAIL busy_extra_burst: got %0d active cycles, expected 0", seen); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL busy_left: got %0d, expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_ready();
      test_digits();
      test_clamp();
      test_no_append();
      test_back_to_back();
      test_mid_reset();
      test_busy_start();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
